// File: rtl/parallel_to_serial_stream.sv
// parallel_to_serial_stream
// Accepts WIDTH-bit words over valid/ready and emits them LANES bits per
// beat, least- or most-significant lanes first. A one-word holding buffer
// behind the shift register lets consecutive words stream with no idle beat.
module parallel_to_serial_stream #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic [LANES-1:0] data_out,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 1);

  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // A word must split into a whole number of beats.
  if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_params
    $error("parallel_to_serial_stream: LANES must be >= 1 and divide WIDTH");
  end

  // Moves the register one beat toward its output end, zero-filling behind.
  function automatic logic [WIDTH-1:0] shift_beat(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return v << LANES;
    end else begin
      return v >> LANES;
    end
  endfunction

  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic [CW-1:0]    beats_left, beats_left_nxt;
  logic             word_done_nxt;

  logic             accept;
  logic             consume;
  logic             last_beat;
  logic [LANES-1:0] head;

  // The beat currently presented sits at the output end of the register.
  if (MSB_FIRST) begin : g_head_msb
    assign head = sreg[WIDTH-1 -: LANES];
  end else begin : g_head_lsb
    assign head = sreg[LANES-1:0];
  end

  assign out_valid = (beats_left != '0);
  assign data_out  = out_valid ? head : '0;
  assign in_ready  = !hold_full && !flush;
  assign busy      = out_valid || hold_full;

  assign accept    = in_valid && in_ready;
  assign consume   = shift_en && out_valid;
  assign last_beat = consume && (beats_left == ONE_C);

  // Next-state: flush wins; otherwise shift on consume, reload on the last
  // beat (hold first, then a fresh word), or park an accepted word.
  always_comb begin
    sreg_nxt       = sreg;
    hold_nxt       = hold;
    hold_full_nxt  = hold_full;
    beats_left_nxt = beats_left;
    word_done_nxt  = 1'b0;

    if (flush) begin
      sreg_nxt       = '0;
      hold_nxt       = '0;
      hold_full_nxt  = 1'b0;
      beats_left_nxt = '0;
    end else if (last_beat) begin
      word_done_nxt = 1'b1;
      if (hold_full) begin
        sreg_nxt       = hold;
        beats_left_nxt = BEATS_C;
        hold_full_nxt  = 1'b0;
      end else if (accept) begin
        sreg_nxt       = data_in;
        beats_left_nxt = BEATS_C;
      end else begin
        sreg_nxt       = '0;
        beats_left_nxt = '0;
      end
    end else begin
      if (consume) begin
        sreg_nxt       = shift_beat(sreg);
        beats_left_nxt = beats_left - ONE_C;
      end
      if (accept) begin
        if (beats_left == '0) begin
          sreg_nxt       = data_in;
          beats_left_nxt = BEATS_C;
        end else begin
          hold_nxt      = data_in;
          hold_full_nxt = 1'b1;
        end
      end
    end
  end

  // State register; reset discards any buffered data immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      beats_left <= '0;
      word_done  <= 1'b0;
    end else begin
      sreg       <= sreg_nxt;
      hold       <= hold_nxt;
      hold_full  <= hold_full_nxt;
      beats_left <= beats_left_nxt;
      word_done  <= word_done_nxt;
    end
  end

  // in_ready is low whenever hold is full, so a drain and an accept can
  // never collide on the holding buffer.
  a_no_hold_collision : assert property (
    @(posedge clk) disable iff (!rst_n) !(last_beat && hold_full && accept)
  );

  // The holding buffer only ever fills behind an active shift register.
  a_hold_implies_active : assert property (
    @(posedge clk) disable iff (!rst_n) hold_full |-> (beats_left != '0)
  );

  // The beat counter never exceeds one word's worth of beats.
  a_beats_in_range : assert property (
    @(posedge clk) disable iff (!rst_n) beats_left <= BEATS_C
  );

endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// Bench for parallel_to_serial_stream: two 8-bit/2-lane instances (LSB- and
// MSB-first) share stimulus with a 3-bit/1-lane instance; a scoreboard
// predicts every beat of the 8-bit instances from the accepted words.
module tb_parallel_to_serial_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       shift_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] data_in3 = 3'b000;

  logic       l_in_ready, l_out_valid, l_word_done, l_busy;
  logic [1:0] l_data_out;
  logic       m_in_ready, m_out_valid, m_word_done, m_busy;
  logic [1:0] m_data_out;
  logic       w_in_ready, w_out_valid, w_word_done, w_busy;
  logic [0:0] w_data_out;

  parallel_to_serial_stream #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(l_in_ready), .shift_en(shift_en),
    .data_out(l_data_out), .out_valid(l_out_valid), .word_done(l_word_done),
    .busy(l_busy)
  );

  parallel_to_serial_stream #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(m_in_ready), .shift_en(shift_en),
    .data_out(m_data_out), .out_valid(m_out_valid), .word_done(m_word_done),
    .busy(m_busy)
  );

  parallel_to_serial_stream #(.WIDTH(3), .LANES(1), .MSB_FIRST(1'b0)) u_w3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in3),
    .in_valid(in_valid), .in_ready(w_in_ready), .shift_en(shift_en),
    .data_out(w_data_out), .out_valid(w_out_valid), .word_done(w_word_done),
    .busy(w_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] q_l[$];
  logic [1:0] q_m[$];

  // Scoreboard: decisions sampled mid-cycle take effect at the next rising edge.
  always @(negedge clk) begin : scoreboard
    logic [1:0] e;
    if (!rst_n || flush) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (shift_en && l_out_valid) begin
        n_checks++;
        if (q_l.size() == 0) begin
          $display("FAIL sb_lsb_underflow: got beat %0d, none expected", l_data_out);
        end else begin
          e = q_l.pop_front();
          if (l_data_out !== e) $display("FAIL sb_lsb_beat: got %0d want %0d", l_data_out, e);
          else n_pass++;
        end
      end
      if (shift_en && m_out_valid) begin
        n_checks++;
        if (q_m.size() == 0) begin
          $display("FAIL sb_msb_underflow: got beat %0d, none expected", m_data_out);
        end else begin
          e = q_m.pop_front();
          if (m_data_out !== e) $display("FAIL sb_msb_beat: got %0d want %0d", m_data_out, e);
          else n_pass++;
        end
      end
      if (in_valid && l_in_ready)
        for (int i = 0; i < 4; i++) q_l.push_back(data_in[2*i +: 2]);
      if (in_valid && m_in_ready)
        for (int i = 0; i < 4; i++) q_m.push_back(data_in[6-2*i +: 2]);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; shift_en = 1'b0;
    data_in = 8'h00; data_in3 = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (l_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", l_out_valid); else n_pass++;
    n_checks++; if (l_data_out !== 2'd0) $display("FAIL reset_data_out: got %0d want 0", l_data_out); else n_pass++;
    n_checks++; if (l_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", l_in_ready); else n_pass++;
    n_checks++; if (l_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", l_busy); else n_pass++;
    n_checks++; if (l_word_done !== 1'b0) $display("FAIL reset_word_done: got %b want 0", l_word_done); else n_pass++;
    n_checks++; if (w_out_valid !== 1'b0) $display("FAIL reset_w3_out_valid: got %b want 0", w_out_valid); else n_pass++;
    do_reset();
  endtask

  task automatic test_w3_basic();
    logic [2:0] w;
    w = 3'b011;
    do_reset();
    data_in3 = w; in_valid = 1'b1; shift_en = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0; shift_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (w_out_valid !== 1'b1) $display("FAIL w3_out_valid[%0d]: got %b want 1", i, w_out_valid); else n_pass++;
      n_checks++; if (w_data_out !== w[i]) $display("FAIL w3_beat[%0d]: got %b want %b", i, w_data_out, w[i]); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (w_word_done !== 1'b1) $display("FAIL w3_word_done: got %b want 1", w_word_done); else n_pass++;
    n_checks++; if (w_out_valid !== 1'b0) $display("FAIL w3_end_valid: got %b want 0", w_out_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (w_out_valid !== 1'b0 || w_data_out !== 1'b0 || w_word_done !== 1'b0)
        $display("FAIL w3_idle[%0d]: got vld=%b data=%b done=%b want 0/0/0", i, w_out_valid, w_data_out, w_word_done);
      else n_pass++;
    end
    @(posedge clk); #1 shift_en = 1'b0;
  endtask

  task automatic test_single_word();
    int l_done, m_done, l_vld, m_vld;
    l_done = 0; m_done = 0; l_vld = 0; m_vld = 0;
    do_reset();
    data_in = 8'hB4; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; shift_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (l_word_done) l_done++;
      if (m_word_done) m_done++;
      if (l_out_valid) l_vld++;
      if (m_out_valid) m_vld++;
    end
    n_checks++; if (l_done != 1) $display("FAIL single_lsb_done: got %0d pulses want 1", l_done); else n_pass++;
    n_checks++; if (m_done != 1) $display("FAIL single_msb_done: got %0d pulses want 1", m_done); else n_pass++;
    n_checks++; if (l_vld != 4) $display("FAIL single_lsb_beats: got %0d want 4", l_vld); else n_pass++;
    n_checks++; if (m_vld != 4) $display("FAIL single_msb_beats: got %0d want 4", m_vld); else n_pass++;
    n_checks++; if (q_l.size() != 0 || q_m.size() != 0)
      $display("FAIL single_sb_left: got %0d/%0d beats pending want 0/0", q_l.size(), q_m.size());
    else n_pass++;
    @(posedge clk); #1 shift_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit exp_rdy [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit exp_vld [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int done;
    logic acc;
    done = 0;
    do_reset();
    data_in = 8'hB4; in_valid = 1'b1; shift_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (l_in_ready !== exp_rdy[k]) $display("FAIL b2b_in_ready[%0d]: got %b want %b", k, l_in_ready, exp_rdy[k]); else n_pass++;
      n_checks++; if (l_out_valid !== exp_vld[k]) $display("FAIL b2b_out_valid[%0d]: got %b want %b", k, l_out_valid, exp_vld[k]); else n_pass++;
      if (l_word_done) done++;
      acc = in_valid && l_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (data_in == 8'hB4) data_in = 8'h1E;
        else in_valid = 1'b0;
      end
    end
    n_checks++; if (done != 2) $display("FAIL b2b_word_done: got %0d pulses want 2", done); else n_pass++;
    shift_en = 1'b0;
  endtask

  // Leaves 0xFF in the shift register and 0xAA in the holding buffer.
  task automatic load_two_words();
    shift_en = 1'b0; data_in = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1 data_in = 8'hAA;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    load_two_words();
    data_in = 8'h55; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (l_out_valid !== 1'b1 || l_data_out !== 2'd3)
        $display("FAIL stall_beat[%0d]: got vld=%b data=%0d want 1/3", i, l_out_valid, l_data_out);
      else n_pass++;
      n_checks++; if (l_in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", i, l_in_ready); else n_pass++;
    end
    @(posedge clk); #1 in_valid = 1'b0; shift_en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (l_out_valid !== 1'b0 || l_busy !== 1'b0)
      $display("FAIL stall_drain: got vld=%b busy=%b want 0/0", l_out_valid, l_busy);
    else n_pass++;
    n_checks++; if (q_l.size() != 0) $display("FAIL stall_sb_left: got %0d beats pending want 0", q_l.size()); else n_pass++;
    @(posedge clk); #1 shift_en = 1'b0;
  endtask

  task automatic test_clear_mid_word();
    // Asynchronous reset in the middle of a word.
    do_reset();
    load_two_words();
    shift_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    n_checks++; if (l_out_valid !== 1'b0 || l_busy !== 1'b0 || l_in_ready !== 1'b1)
      $display("FAIL rst_mid: got vld=%b busy=%b rdy=%b want 0/0/1", l_out_valid, l_busy, l_in_ready);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (l_out_valid !== 1'b0 || l_data_out !== 2'd0)
        $display("FAIL rst_after[%0d]: got vld=%b data=%0d want 0/0", i, l_out_valid, l_data_out);
      else n_pass++;
    end
    // Synchronous flush with stimulus that would otherwise accept and consume.
    do_reset();
    load_two_words();
    flush = 1'b1; shift_en = 1'b1; in_valid = 1'b1; data_in = 8'h55;
    @(negedge clk);
    n_checks++; if (l_in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", l_in_ready); else n_pass++;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (l_out_valid !== 1'b0 || l_busy !== 1'b0 || l_in_ready !== 1'b1)
      $display("FAIL flush_after: got vld=%b busy=%b rdy=%b want 0/0/1", l_out_valid, l_busy, l_in_ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (l_out_valid !== 1'b0 || l_data_out !== 2'd0 || l_word_done !== 1'b0)
        $display("FAIL flush_shift[%0d]: got vld=%b data=%0d done=%b want 0/0/0", i, l_out_valid, l_data_out, l_word_done);
      else n_pass++;
    end
    @(posedge clk); #1 shift_en = 1'b0;
  endtask

  task automatic test_idle_shift();
    do_reset();
    in_valid = 1'b0; data_in = 8'hFF; shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (l_out_valid !== 1'b0 || l_data_out !== 2'd0 || l_word_done !== 1'b0)
        $display("FAIL idle[%0d]: got vld=%b data=%0d done=%b want 0/0/0", i, l_out_valid, l_data_out, l_word_done);
      else n_pass++;
    end
    @(posedge clk); #1 shift_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_w3_basic();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_clear_mid_word();
    test_idle_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial_stream.md
Name: parallel_to_serial_stream

Overview:
Parametrised serializer; successor to the single-bit parallel_to_serial shifter. It accepts WIDTH-bit words over a valid/ready handshake and emits them LANES bits per beat, LSB- or MSB-first. A one-word holding buffer lets back-to-back words stream with no idle beat. It sits between the cell-state word stores and narrow serial links such as the display/debug shift-out path.

Parameters:
WIDTH, 8, bits per input word; must be ≥ 1.
LANES, 1, bits emitted per beat; must be ≥ 1 and divide WIDTH exactly (elaboration-time assertion).
MSB_FIRST, 0, 0 = least-significant lanes first; 1 = most-significant lanes first.
Derived: BEATS = WIDTH/LANES; counter width CW = $clog2(BEATS+1).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all buffered data
data_in  input  WIDTH  parallel word
in_valid  input  1  data_in valid
in_ready  output  1  block can accept a word this cycle
shift_en  input  1  consumer takes current beat
data_out  output  LANES  current beat; zero when out_valid=0
out_valid  output  1  data_out holds a real beat
word_done  output  1  one-cycle pulse after final beat of a word consumed
busy  output  1  shift register or holding buffer occupied

Behaviour:
- Reset (rst_n low, async): sreg=0, hold=0, hold_full=0, beats_left=0, word_done=0. Outputs: data_out=0, out_valid=0, in_ready=1, busy=0.
- State: sreg (WIDTH), beats_left (CW), hold (WIDTH), hold_full. Active state: beats_left≠0.
- Output mapping (combinational from sreg):
  - out_valid = (beats_left≠0).
  - data_out = sreg[LANES-1:0] if MSB_FIRST=0, else sreg[WIDTH-1 -: LANES]; forced 0 when !out_valid.
- in_ready = !hold_full && !flush. Accept = in_valid && in_ready.
- Beat consume = shift_en && out_valid. Shift_en while !out_valid is ignored: no state change, data_out stays 0.
- On consume:
  - sreg shifts by LANES toward the output end, zero-filled.
  - beats_left decrements.
- Last beat (consume with beats_left==1), reload in priority order with no bubble:
  1. If hold_full, sreg<=hold, beats_left<=BEATS, hold_full<=0.
  2. Else if accept this cycle, sreg<=data_in, beats_left<=BEATS.
  3. Else beats_left<=0 and sreg<=0.
- Accept when sreg is empty (beats_left==0): word loads straight into sreg, beats_left<=BEATS. out_valid rises next cycle; latency is 1 clock from accept to first beat.
- Accept while sreg is active and not emptying: word goes to hold, hold_full<=1.
- A word accepted in the same cycle hold drains to sreg (priority 1) lands in hold. in_ready was 1 only because hold_full was 0 at the start of that cycle, so this cannot occur; it is covered by an assertion.
- word_done is registered: 1 for exactly one clk after any last-beat consume, otherwise 0.
- busy = out_valid || hold_full.
- flush=1: next edge clears sreg, hold, hold_full, beats_left and word_done. flush overrides accept and consume in the same cycle, and in_ready=0 while flush is high.
- Reset mid-word: all data discarded immediately (async). After release, shift_en produces only zeros with out_valid=0.
- Max throughput: one beat per clock. With continuous in_valid and shift_en, out_valid stays high across word boundaries.

Test Plan:
- WIDTH=3, LANES=1, LSB-first; accept 3'b011, then shift_en=1 → data_out 1,1,0 with out_valid=1. Next cycle word_done=1, then out_valid=0 and data_out=0 for ≥3 further shifts.
- WIDTH=8, LANES=2; word 0xB4. LSB-first → beats 0,1,3,2. MSB_FIRST=1 → beats 2,3,1,0. word_done pulses once per word.
- WIDTH=8, LANES=2; stream 0xB4 then 0x1E with in_valid and shift_en high throughout → 8 consecutive valid beats (0,1,3,2,2,3,1,0) with no gap. in_ready drops to 0 only while hold is full.
- Load 0xFF, shift_en=0 for 20 cycles → out_valid=1, data_out stays 3 (LANES=2) and no beats are lost. A third word is rejected (in_ready=0) while both sreg and hold are full.
- Load 0xFF and a held 0xAA, then pulse rst_n low mid-word (and separately assert flush) → out_valid=0, busy=0, in_ready=1, and 4 shifts yield data_out=0.
- in_valid=0 with data_in=0xFF, shift_en=1 for 8 cycles → out_valid=0, data_out=0, and word_done is never asserted.
